rc_motor_ctrl: RTL and testbench
================================

RC_MOTOR_CTRL -- requirements
Module: rc_motor_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- PWM_PERIOD, 2500, PWM period in clk_50 cycles (20 kHz at 50 MHz).
- DUTY_FWD, 2000, high-cycles per period for 'w'/'s'.
- DUTY_TURN, 1250, high-cycles per period for 'a'/'d'.
- TIMEOUT_CYC, 25000000, cycles without a valid command before failsafe (0.5 s).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_50, in, 1, sole clock.
- rst, in, 1, reset, asynchronous, active-high.
- rx_data, in, 8, byte from the upstream UART receiver.
- rx_valid, in, 1, one-cycle strobe qualifying rx_data.
- led, out, 4, one-hot active command: [3]=w, [2]=a, [1]=s, [0]=d.
- ml_pwm / ml_dir, out, 1 each, left motor PWM and direction (1=forward).
- mr_pwm / mr_dir, out, 1 each, right motor PWM and direction (1=forward).
- cmd_err, out, 1, one-cycle pulse on an unrecognised byte.
- timeout, out, 1, level, high while in FAILSAFE.
REQ-003 The block SHALL use one clock (clk_50); reset is asynchronous and active-high (rst).

Function
REQ-004 Decode SHALL be:
- 0x77/0x57 'w': both motors forward, DUTY_FWD.
- 0x73/0x53 's': both motors reverse, DUTY_FWD.
- 0x61/0x41 'a': left reverse, right forward, DUTY_TURN.
- 0x64/0x44 'd': left forward, right reverse, DUTY_TURN.
- 0x78/0x20 ('x' or space): stop, duty 0.
REQ-005 Any other byte with rx_valid SHALL pulse cmd_err for exactly 1 cycle (registered, cycle after the strobe), with no change to state, targets, or timeout counter.
REQ-006 FSM states SHALL be IDLE, DRIVE and FAILSAFE.
- Reset enters IDLE.
- Motion command from any state enters DRIVE.
- Stop command from any state enters IDLE.
- DRIVE with timeout counter == TIMEOUT_CYC-1 enters FAILSAFE.
REQ-007 The timeout counter SHALL clear on every valid motion command, count only in DRIVE, and hold at 0 in IDLE and FAILSAFE.
REQ-008 If rx_valid with a recognised byte coincides with timeout expiry, the command SHALL win: state follows REQ-006 for the command and the counter clears.
REQ-009 In IDLE and FAILSAFE, motor target duties SHALL be 0 and led SHALL be 4'b0000; timeout SHALL be 1 only in FAILSAFE.
REQ-010 led SHALL update 1 cycle after the accepting rx_valid cycle, independent of PWM alignment.
REQ-011 A free-running PWM counter SHALL count 0..PWM_PERIOD-1 and wrap; pwm output = (counter < active_duty), registered.
- Duty >= PWM_PERIOD gives constant high; duty 0 gives constant low.
REQ-012 Each motor SHALL latch its active duty and direction only at counter wrap (PWM_PERIOD-1 -> 0), so no partial periods are produced.
- The latest target before the wrap is used; earlier targets in the same period are discarded.
REQ-013 Dead time: if a motor's target direction differs from its current dir and target duty is nonzero, the next wrap SHALL apply duty 0 with dir unchanged.
- The following wrap flips dir and applies target duty.
- Dead time is exactly one full period of pwm low.
REQ-014 A target direction change with target duty 0 SHALL update dir at the next wrap with no dead period.
REQ-015 If the target changes during a dead period, the new target SHALL be evaluated at the next wrap under REQ-012 to REQ-014.

Reset
REQ-016 rst high SHALL immediately force: state IDLE; led=0; ml_pwm=mr_pwm=0; ml_dir=mr_dir=1; cmd_err=0; timeout=0; PWM and timeout counters=0; active and target duties=0.
REQ-017 Reset asserted mid-period or mid-dead-time SHALL abandon it; after release the first wrap occurs PWM_PERIOD cycles later.

Verification (PWM_PERIOD=10, DUTY_FWD=8, DUTY_TURN=5, TIMEOUT_CYC=100)
REQ-018 The bench SHALL cover the following directed scenarios:
- 'w' (0x77) strobe -> led=1000 next cycle; from next wrap, ml_pwm/mr_pwm high 8 of every 10 cycles, both dir=1.
- 'w' then 's' mid-period -> one full period pwm=0 with dir=1, then dir=0 and 8/10 duty; led=0010 one cycle after the 's' strobe.
- 'd' then no input for 100 cycles -> timeout=1, led=0000, pwm constantly low from the next wrap; then 'a' -> timeout=0, left dir=0, right dir=1, 5/10 duty after any required dead period.
- 0x51 'Q' while driving 'w' -> cmd_err high exactly 1 cycle; led and pwm unchanged; timeout still fires 100 cycles after the 'w'.
- 'w' strobe on the exact expiry cycle -> no FAILSAFE entry; timeout stays 0.
- rst asserted mid-period while driving -> all outputs at reset values within the same cycle; after release, 'x' -> state stays IDLE, pwm low.

Source files
------------

// File: rtl/rc_motor_ctrl.sv
// Keyboard-driven two-motor controller: decodes UART command bytes into motor targets,
// runs a drive watchdog, and produces period-aligned PWM with a one-period reversal dead time.
module rc_motor_ctrl #(
    parameter int unsigned PWM_PERIOD  = 2500,
    parameter int unsigned DUTY_FWD    = 2000,
    parameter int unsigned DUTY_TURN   = 1250,
    parameter int unsigned TIMEOUT_CYC = 25000000
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [3:0] led,
    output logic       ml_pwm,
    output logic       ml_dir,
    output logic       mr_pwm,
    output logic       mr_dir,
    output logic       cmd_err,
    output logic       timeout
);

    localparam int unsigned DUTY_MAX =
        (PWM_PERIOD > DUTY_FWD) ? ((PWM_PERIOD > DUTY_TURN) ? PWM_PERIOD : DUTY_TURN)
                                : ((DUTY_FWD > DUTY_TURN) ? DUTY_FWD : DUTY_TURN);
    localparam int DW = $clog2(DUTY_MAX + 1);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [DW-1:0] CNT_LAST = DW'(PWM_PERIOD - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRIVE    = 2'd1,
        ST_FAILSAFE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_to_cnt;
    logic [TW-1:0] w_to_cnt_nxt;
    logic [3:0]    r_led;
    logic [3:0]    w_led_nxt;
    logic          r_cmd_err;
    logic          r_timeout;
    // Motor index 0 is the left motor, 1 the right motor.
    logic [1:0]    r_tgt_dir;
    logic [1:0]    w_tgt_dir_nxt;
    logic [DW-1:0] r_tgt_duty;
    logic [DW-1:0] w_tgt_duty_nxt;

    logic          w_is_motion;
    logic          w_is_stop;
    logic [3:0]    w_cmd_led;
    logic [1:0]    w_cmd_dir;
    logic [DW-1:0] w_cmd_duty;
    logic          w_acc_motion;
    logic          w_acc_stop;
    logic          w_acc_bad;

    logic [DW-1:0] r_pwm_cnt;
    logic [DW-1:0] w_pwm_cnt_nxt;
    logic          w_wrap;
    logic [DW-1:0] r_act_duty     [2];
    logic [DW-1:0] w_act_duty_nxt [2];
    logic [1:0]    r_act_dir;
    logic [1:0]    w_act_dir_nxt;
    logic [1:0]    r_dead;
    logic [1:0]    w_dead_nxt;
    logic [1:0]    r_pwm;
    logic [1:0]    w_pwm_nxt;

    // Command byte decode into led pattern, per-motor direction and duty magnitude.
    always_comb begin
        w_is_motion = 1'b0;
        w_is_stop   = 1'b0;
        w_cmd_led   = 4'b0000;
        w_cmd_dir   = 2'b11;
        w_cmd_duty  = {DW{1'b0}};
        case (rx_data)
            8'h77, 8'h57: begin
                w_is_motion = 1'b1;
                w_cmd_led   = 4'b1000;
                w_cmd_dir   = 2'b11;
                w_cmd_duty  = DW'(DUTY_FWD);
            end
            8'h73, 8'h53: begin
                w_is_motion = 1'b1;
                w_cmd_led   = 4'b0010;
                w_cmd_dir   = 2'b00;
                w_cmd_duty  = DW'(DUTY_FWD);
            end
            8'h61, 8'h41: begin
                w_is_motion = 1'b1;
                w_cmd_led   = 4'b0100;
                w_cmd_dir   = 2'b10;
                w_cmd_duty  = DW'(DUTY_TURN);
            end
            8'h64, 8'h44: begin
                w_is_motion = 1'b1;
                w_cmd_led   = 4'b0001;
                w_cmd_dir   = 2'b01;
                w_cmd_duty  = DW'(DUTY_TURN);
            end
            8'h78, 8'h20: w_is_stop = 1'b1;
            default:      w_is_stop = 1'b0;
        endcase
    end

    assign w_acc_motion = rx_valid & w_is_motion;
    assign w_acc_stop   = rx_valid & w_is_stop;
    assign w_acc_bad    = rx_valid & ~w_is_motion & ~w_is_stop;

    // Mode transitions; a recognised command always outranks watchdog expiry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_acc_motion) w_state_nxt = ST_DRIVE;
                else              w_state_nxt = ST_IDLE;
            end
            ST_DRIVE: begin
                if (w_acc_motion)            w_state_nxt = ST_DRIVE;
                else if (w_acc_stop)         w_state_nxt = ST_IDLE;
                else if (r_to_cnt == TO_LAST) w_state_nxt = ST_FAILSAFE;
                else                         w_state_nxt = ST_DRIVE;
            end
            ST_FAILSAFE: begin
                if (w_acc_motion)    w_state_nxt = ST_DRIVE;
                else if (w_acc_stop) w_state_nxt = ST_IDLE;
                else                 w_state_nxt = ST_FAILSAFE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Watchdog count, led and motor targets; leaving DRIVE zeroes duty but keeps direction.
    always_comb begin
        w_to_cnt_nxt   = {TW{1'b0}};
        w_led_nxt      = 4'b0000;
        w_tgt_dir_nxt  = r_tgt_dir;
        w_tgt_duty_nxt = {DW{1'b0}};
        if (w_acc_motion) begin
            w_led_nxt      = w_cmd_led;
            w_tgt_dir_nxt  = w_cmd_dir;
            w_tgt_duty_nxt = w_cmd_duty;
        end else if (w_state_nxt == ST_DRIVE) begin
            w_to_cnt_nxt   = r_to_cnt + TW'(1);
            w_led_nxt      = r_led;
            w_tgt_duty_nxt = r_tgt_duty;
        end else begin
            w_to_cnt_nxt   = {TW{1'b0}};
            w_led_nxt      = 4'b0000;
            w_tgt_duty_nxt = {DW{1'b0}};
        end
    end

    // Control registers.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_to_cnt   <= {TW{1'b0}};
            r_led      <= 4'b0000;
            r_cmd_err  <= 1'b0;
            r_timeout  <= 1'b0;
            r_tgt_dir  <= 2'b11;
            r_tgt_duty <= {DW{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_led      <= w_led_nxt;
            r_cmd_err  <= w_acc_bad;
            r_timeout  <= (w_state_nxt == ST_FAILSAFE);
            r_tgt_dir  <= w_tgt_dir_nxt;
            r_tgt_duty <= w_tgt_duty_nxt;
        end
    end

    assign w_wrap        = (r_pwm_cnt == CNT_LAST);
    assign w_pwm_cnt_nxt = w_wrap ? {DW{1'b0}} : (r_pwm_cnt + DW'(1));

    // Per-motor period latch: a reversal under load first spends one whole period at zero duty.
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            w_act_duty_nxt[m] = r_act_duty[m];
            w_act_dir_nxt[m]  = r_act_dir[m];
            w_dead_nxt[m]     = r_dead[m];
            if (!w_wrap) begin
                w_dead_nxt[m] = r_dead[m];
            end else if (r_dead[m]) begin
                w_act_dir_nxt[m]  = r_tgt_dir[m];
                w_act_duty_nxt[m] = r_tgt_duty;
                w_dead_nxt[m]     = 1'b0;
            end else if ((r_tgt_dir[m] != r_act_dir[m]) && (r_tgt_duty != {DW{1'b0}})) begin
                w_act_duty_nxt[m] = {DW{1'b0}};
                w_dead_nxt[m]     = 1'b1;
            end else begin
                w_act_dir_nxt[m]  = r_tgt_dir[m];
                w_act_duty_nxt[m] = r_tgt_duty;
            end
            w_pwm_nxt[m] = (w_pwm_cnt_nxt < w_act_duty_nxt[m]);
        end
    end

    // PWM counter, latched duties/directions and registered pwm pins.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= {DW{1'b0}};
            r_act_dir <= 2'b11;
            r_dead    <= 2'b00;
            r_pwm     <= 2'b00;
            for (int m = 0; m < 2; m++) begin
                r_act_duty[m] <= {DW{1'b0}};
            end
        end else begin
            r_pwm_cnt <= w_pwm_cnt_nxt;
            r_act_dir <= w_act_dir_nxt;
            r_dead    <= w_dead_nxt;
            r_pwm     <= w_pwm_nxt;
            for (int m = 0; m < 2; m++) begin
                r_act_duty[m] <= w_act_duty_nxt[m];
            end
        end
    end

    assign led     = r_led;
    assign ml_pwm  = r_pwm[0];
    assign mr_pwm  = r_pwm[1];
    assign ml_dir  = r_act_dir[0];
    assign mr_dir  = r_act_dir[1];
    assign cmd_err = r_cmd_err;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_rc_motor_ctrl.sv
// Bench for rc_motor_ctrl: decode table, directed multi-cycle sequences, and random traffic
// compared each cycle against a time-based reference model.
module tb_rc_motor_ctrl;

    localparam int P  = 10;
    localparam int DF = 8;
    localparam int DT = 5;
    localparam int TO = 100;

    logic       clk_50 = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] led;
    logic       ml_pwm, ml_dir, mr_pwm, mr_dir, cmd_err, timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk_50 = ~clk_50;

    rc_motor_ctrl #(
        .PWM_PERIOD(P), .DUTY_FWD(DF), .DUTY_TURN(DT), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_50(clk_50), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .led(led), .ml_pwm(ml_pwm), .ml_dir(ml_dir), .mr_pwm(mr_pwm), .mr_dir(mr_dir),
        .cmd_err(cmd_err), .timeout(timeout)
    );

    // Reference model: time since reset, last accepted motion command and its time stamp.
    int         m_t;
    bit         m_drv;
    int         m_last;
    logic [3:0] m_led_cmd;
    int         m_duty_cmd;
    bit         m_tdir  [2];
    int         m_aduty [2];
    bit         m_adir  [2];
    bit         m_dead  [2];
    bit         m_err;

    typedef struct {
        logic [7:0] data;
        logic [3:0] exp_led;
        logic       exp_err;
    } vec_t;
    vec_t tbl [13];
    logic [7:0] pool [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void decode(input logic [7:0] b, output int kind, output logic [3:0] l,
                                   output bit dl, output bit dr, output int duty);
        kind = 0; l = 4'b0000; dl = 1'b1; dr = 1'b1; duty = 0;
        case (b)
            8'h77, 8'h57: begin kind = 1; l = 4'b1000; dl = 1'b1; dr = 1'b1; duty = DF; end
            8'h73, 8'h53: begin kind = 1; l = 4'b0010; dl = 1'b0; dr = 1'b0; duty = DF; end
            8'h61, 8'h41: begin kind = 1; l = 4'b0100; dl = 1'b0; dr = 1'b1; duty = DT; end
            8'h64, 8'h44: begin kind = 1; l = 4'b0001; dl = 1'b1; dr = 1'b0; duty = DT; end
            8'h78, 8'h20: kind = 2;
            default:      kind = 0;
        endcase
    endfunction

    function automatic bit m_failsafe();
        return m_drv && ((m_t - m_last) >= TO);
    endfunction

    function automatic int m_target_duty();
        return (m_drv && ((m_t - m_last) < TO)) ? m_duty_cmd : 0;
    endfunction

    task automatic model_reset();
        m_t = 0; m_drv = 1'b0; m_last = 0; m_led_cmd = 4'b0000; m_duty_cmd = 0; m_err = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_tdir[m] = 1'b1; m_aduty[m] = 0; m_adir[m] = 1'b1; m_dead[m] = 1'b0;
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, compare every output.
    task automatic step(input bit v, input logic [7:0] d);
        int kind, duty;
        logic [3:0] l;
        bit dl, dr;
        rx_valid = v;
        rx_data  = d;
        @(posedge clk_50);
        #1;
        rx_valid = 1'b0;
        if (((m_t + 1) % P) == 0) begin
            int td;
            td = m_target_duty();
            for (int m = 0; m < 2; m++) begin
                if (m_dead[m]) begin
                    m_adir[m] = m_tdir[m]; m_aduty[m] = td; m_dead[m] = 1'b0;
                end else if ((m_tdir[m] != m_adir[m]) && (td != 0)) begin
                    m_aduty[m] = 0; m_dead[m] = 1'b1;
                end else begin
                    m_adir[m] = m_tdir[m]; m_aduty[m] = td;
                end
            end
        end
        m_t++;
        decode(d, kind, l, dl, dr, duty);
        m_err = v && (kind == 0);
        if (v && kind == 1) begin
            m_drv = 1'b1; m_last = m_t; m_led_cmd = l; m_duty_cmd = duty;
            m_tdir[0] = dl; m_tdir[1] = dr;
        end else if (v && kind == 2) begin
            m_drv = 1'b0;
        end
        chk("model_led", 32'(led), 32'((m_drv && !m_failsafe()) ? m_led_cmd : 4'b0000));
        chk("model_timeout", 32'(timeout), 32'(m_failsafe()));
        chk("model_cmd_err", 32'(cmd_err), 32'(m_err));
        chk("model_ml_pwm", 32'(ml_pwm), 32'((m_t % P) < m_aduty[0]));
        chk("model_mr_pwm", 32'(mr_pwm), 32'((m_t % P) < m_aduty[1]));
        chk("model_ml_dir", 32'(ml_dir), 32'(m_adir[0]));
        chk("model_mr_dir", 32'(mr_dir), 32'(m_adir[1]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    // Asserts reset mid-cycle, checks outputs before the next edge, releases after one edge.
    task automatic apply_reset(input string nm);
        rst = 1'b1;
        #1;
        chk({nm, "_led"}, 32'(led), 32'd0);
        chk({nm, "_ml_pwm"}, 32'(ml_pwm), 32'd0);
        chk({nm, "_mr_pwm"}, 32'(mr_pwm), 32'd0);
        chk({nm, "_ml_dir"}, 32'(ml_dir), 32'd1);
        chk({nm, "_mr_dir"}, 32'(mr_dir), 32'd1);
        chk({nm, "_cmd_err"}, 32'(cmd_err), 32'd0);
        chk({nm, "_timeout"}, 32'(timeout), 32'd0);
        @(posedge clk_50);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Aligns to the next period start, then counts pwm-high and dir-match cycles over one period.
    task automatic period_check(input string nm, input int el, input int er, input bit edl, input bit edr);
        int hl, hr, dlm, drm;
        hl = 0; hr = 0; dlm = 0; drm = 0;
        for (int i = 0; i < P && (m_t % P) != 0; i++) step(1'b0, 8'h00);
        for (int i = 0; i < P; i++) begin
            if (ml_pwm === 1'b1) hl++;
            if (mr_pwm === 1'b1) hr++;
            if (ml_dir === edl) dlm++;
            if (mr_dir === edr) drm++;
            step(1'b0, 8'h00);
        end
        chk({nm, "_left_high"}, 32'(hl), 32'(el));
        chk({nm, "_right_high"}, 32'(hr), 32'(er));
        chk({nm, "_left_dir"}, 32'(dlm), 32'(P));
        chk({nm, "_right_dir"}, 32'(drm), 32'(P));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "simulation time limit");
    end

    initial begin
        tbl[0]  = '{8'h77, 4'b1000, 1'b0};
        tbl[1]  = '{8'h51, 4'b1000, 1'b1};
        tbl[2]  = '{8'h73, 4'b0010, 1'b0};
        tbl[3]  = '{8'h61, 4'b0100, 1'b0};
        tbl[4]  = '{8'h64, 4'b0001, 1'b0};
        tbl[5]  = '{8'h20, 4'b0000, 1'b0};
        tbl[6]  = '{8'h57, 4'b1000, 1'b0};
        tbl[7]  = '{8'h00, 4'b1000, 1'b1};
        tbl[8]  = '{8'h53, 4'b0010, 1'b0};
        tbl[9]  = '{8'h41, 4'b0100, 1'b0};
        tbl[10] = '{8'h44, 4'b0001, 1'b0};
        tbl[11] = '{8'h78, 4'b0000, 1'b0};
        tbl[12] = '{8'hFF, 4'b0000, 1'b1};
        pool = '{8'h77, 8'h57, 8'h73, 8'h53, 8'h61, 8'h41,
                 8'h64, 8'h44, 8'h78, 8'h20, 8'h51, 8'h00};
        model_reset();

        @(posedge clk_50);
        #1;
        apply_reset("reset_init");

        // Decode table: led and cmd_err one cycle after each strobe.
        for (int i = 0; i < 13; i++) begin
            step(1'b1, tbl[i].data);
            chk($sformatf("table%0d_led", i), 32'(led), 32'(tbl[i].exp_led));
            chk($sformatf("table%0d_err", i), 32'(cmd_err), 32'(tbl[i].exp_err));
            chk($sformatf("table%0d_timeout", i), 32'(timeout), 32'd0);
        end

        // Forward, then reverse mid-period with one dead period.
        apply_reset("reset_ws");
        step(1'b1, 8'h77);
        chk("w_led", 32'(led), 32'b1000);
        period_check("w_drive", DF, DF, 1'b1, 1'b1);
        idle(3);
        step(1'b1, 8'h73);
        chk("s_led", 32'(led), 32'b0010);
        period_check("s_dead", 0, 0, 1'b1, 1'b1);
        period_check("s_drive", DF, DF, 1'b0, 1'b0);

        // Right turn, watchdog expiry, then left turn recovering after dead time.
        apply_reset("reset_d");
        step(1'b1, 8'h64);
        idle(99);
        chk("d_before_expiry", 32'(timeout), 32'd0);
        step(1'b0, 8'h00);
        chk("d_timeout", 32'(timeout), 32'd1);
        chk("d_timeout_led", 32'(led), 32'd0);
        period_check("failsafe", 0, 0, 1'b1, 1'b0);
        idle(1);
        step(1'b1, 8'h61);
        chk("a_timeout_clear", 32'(timeout), 32'd0);
        chk("a_led", 32'(led), 32'b0100);
        period_check("a_dead", 0, 0, 1'b1, 1'b0);
        period_check("a_drive", DT, DT, 1'b0, 1'b1);

        // Unknown byte while driving: one-cycle error, watchdog unaffected.
        apply_reset("reset_q");
        step(1'b1, 8'h77);
        idle(3);
        step(1'b1, 8'h51);
        chk("q_err", 32'(cmd_err), 32'd1);
        chk("q_led", 32'(led), 32'b1000);
        step(1'b0, 8'h00);
        chk("q_err_drop", 32'(cmd_err), 32'd0);
        idle(94);
        chk("q_before_expiry", 32'(timeout), 32'd0);
        step(1'b0, 8'h00);
        chk("q_timeout", 32'(timeout), 32'd1);

        // Command on the exact expiry cycle wins.
        apply_reset("reset_exp");
        step(1'b1, 8'h77);
        idle(99);
        step(1'b1, 8'h77);
        chk("exp_timeout", 32'(timeout), 32'd0);
        chk("exp_led", 32'(led), 32'b1000);
        idle(5);
        chk("exp_timeout_later", 32'(timeout), 32'd0);

        // Reset in the middle of a driving period, then stop keeps everything quiet.
        apply_reset("reset_pre_mid");
        step(1'b1, 8'h77);
        period_check("mid_drive", DF, DF, 1'b1, 1'b1);
        idle(4);
        chk("mid_pwm_high", 32'(ml_pwm), 32'd1);
        apply_reset("reset_mid");
        step(1'b1, 8'h78);
        chk("mid_x_led", 32'(led), 32'd0);
        chk("mid_x_timeout", 32'(timeout), 32'd0);
        period_check("mid_x_idle", 0, 0, 1'b1, 1'b1);

        // Random traffic with quiet stretches long enough to trip the watchdog.
        apply_reset("reset_rand");
        step(1'b1, 8'h77);
        for (int i = 0; i < 4000; i++) begin
            bit v;
            logic [7:0] d;
            v = ($urandom_range(0, 7) == 0);
            if (((i / 400) % 2 == 1) && ((i % 400) < 130)) v = 1'b0;
            if ($urandom_range(0, 7) == 0) d = 8'($urandom);
            else d = pool[$urandom_range(0, 11)];
            step(v, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
